// File: rtl/midi_uart_rx.sv
// midi_uart_rx
// Receives 8N1 serial bytes from a MIDI input line and presents each
// correctly framed byte to the system. Every bit is sampled once, at its
// centre, which is derived from the falling edge of the start bit.
//
// Parameters
//   CLK_HZ : system clock frequency in Hz
//   BAUD   : serial bit rate (31250 for MIDI)
//
// Ports
//   clk             : sole clock, rising edge
//   rst             : synchronous active-high reset
//   MIDI_RX         : asynchronous serial input, idle high
//   isByteAvailable : one-cycle pulse when a byte arrives with a good stop bit
//   byteValue       : last good byte, held until the next good byte
//   frame_err       : one-cycle pulse when the stop bit is sampled low
//   rx_busy         : high whenever the receiver is not in IDLE

module midi_uart_rx #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 31250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       MIDI_RX,
  output logic       isByteAvailable,
  output logic [7:0] byteValue,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int BIT_TICKS  = CLK_HZ / BAUD;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  // $clog2(BIT_TICKS) bits always hold BIT_TICKS-1, the largest count used.
  localparam int CNT_W      = $clog2(BIT_TICKS);

  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_TICKS - 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BIT_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state;
  logic             sync_1;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  // Two-flop synchronizer. Both flops reset to the idle (high) level so a
  // line that is low when reset is released cannot look like a start edge
  // before it has propagated through the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= MIDI_RX;
      rx_s   <= sync_1;
    end
  end

  // Receive state machine. The counter restarts on every state entry and on
  // every sample, so the start bit is checked HALF_TICKS cycles after the
  // edge is seen and every later bit exactly BIT_TICKS cycles after that.
  // Transitions only occur at the terminal count, so the counter never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      bit_idx         <= '0;
      shift           <= '0;
      byteValue       <= '0;
      isByteAvailable <= 1'b0;
      frame_err       <= 1'b0;
      rx_busy         <= 1'b0;
    end else begin
      isByteAvailable <= 1'b0;
      frame_err       <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end

        // A start bit that is high again at its centre was a glitch.
        START: begin
          if (cnt == HALF_END) begin
            cnt <= '0;
            if (rx_s) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Data arrives LSB first, so each sample enters at the top and
        // the first bit ends up in bit 0 after eight shifts.
        DATA: begin
          if (cnt == BIT_END) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Returning to IDLE straight from the stop sample lets a start bit
        // that immediately follows the stop bit be caught.
        STOP: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
            if (rx_s) begin
              byteValue       <= shift;
              isByteAvailable <= 1'b1;
              state           <= IDLE;
              rx_busy         <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // A break holds the line low; wait it out so it reports only once.
        WAIT_IDLE: begin
          cnt <= '0;
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          cnt     <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_midi_uart_rx.sv
// tb_midi_uart_rx
// Self-checking bench for midi_uart_rx at 16 clocks per bit. Frames are
// generated bit by bit; every frame pushes its expected outcome onto a
// queue, and a monitor pops and compares each isByteAvailable/frame_err
// pulse against it. A table of frames covers the normal byte path and
// hand-written sequences cover glitch, break and mid-frame reset.

module tb_midi_uart_rx;

  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 100000;
  localparam int BIT    = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       MIDI_RX;
  logic       isByteAvailable;
  logic [7:0] byteValue;
  logic       frame_err;
  logic       rx_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic       is_err;
    logic [7:0] value;
  } event_t;

  typedef struct {
    logic [7:0] data;
    int         gap;
    logic [7:0] exp_value;
  } vec_t;

  event_t     exp_q[$];
  event_t     mon_ev;
  logic [7:0] model_byte;
  vec_t       vecs[7];

  always #5 clk = ~clk;

  midi_uart_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .MIDI_RX        (MIDI_RX),
    .isByteAvailable(isByteAvailable),
    .byteValue      (byteValue),
    .frame_err      (frame_err),
    .rx_busy        (rx_busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Pulses are sampled on the falling edge, away from the DUT's update edge.
  always @(negedge clk) begin
    if (rst === 1'b0 && (isByteAvailable || frame_err)) begin
      if (isByteAvailable && frame_err) begin
        checkOutput("pulses_exclusive", 32'(frame_err), 32'(!isByteAvailable));
      end else if (exp_q.size() == 0) begin
        checkOutput("unexpected_event", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_ev = exp_q.pop_front();
        checkOutput("event_kind", 32'(frame_err), 32'(mon_ev.is_err));
        checkOutput("event_byte", 32'(byteValue), 32'(mon_ev.value));
      end
    end
  end

  task automatic drive_bit(input logic b);
    MIDI_RX = b;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    MIDI_RX = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame: start, 8 data bits LSB first, stop. The expected outcome is
  // queued before the first bit goes out.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
    event_t ev;
    ev.is_err = !stop_bit;
    ev.value  = stop_bit ? data : model_byte;
    exp_q.push_back(ev);
    if (stop_bit) model_byte = data;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    drive_bit(stop_bit);
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int waited = 0;
    while (exp_q.size() != 0 && waited < max_cycles) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checkOutput(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{data: 8'h90, gap: 0,  exp_value: 8'h90};
    vecs[1] = '{data: 8'h3C, gap: 0,  exp_value: 8'h3C};
    vecs[2] = '{data: 8'h64, gap: 20, exp_value: 8'h64};
    vecs[3] = '{data: 8'h00, gap: 0,  exp_value: 8'h00};
    vecs[4] = '{data: 8'hFF, gap: 20, exp_value: 8'hFF};
    vecs[5] = '{data: 8'hA5, gap: 20, exp_value: 8'hA5};
    vecs[6] = '{data: 8'hF8, gap: 20, exp_value: 8'hF8};

    rst        = 1'b1;
    MIDI_RX    = 1'b1;
    model_byte = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("reset_byteValue", 32'(byteValue), 32'h00);
    checkOutput("reset_rx_busy", 32'(rx_busy), 32'd0);
    checkOutput("reset_isByteAvailable", 32'(isByteAvailable), 32'd0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    idle(10);

    // Single frame, back-to-back runs, all-zero and all-one bytes, realtime.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].data, 1'b1);
      if (vecs[i].gap > 0) begin
        idle(vecs[i].gap);
        wait_drain("frame_received", 40);
        checkOutput("idle_rx_busy", 32'(rx_busy), 32'd0);
      end
      checkOutput("table_byteValue", 32'(byteValue), 32'(vecs[i].exp_value));
    end

    // Three-cycle glitch: START entered, rejected at the half-bit sample.
    MIDI_RX = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    MIDI_RX = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("glitch_busy_start", 32'(rx_busy), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("glitch_back_idle", 32'(rx_busy), 32'd0);
    idle(20);
    checkOutput("glitch_byteValue", 32'(byteValue), 32'hF8);

    // Bad stop bit followed by a long break: exactly one frame_err.
    applyStimulus(8'h55, 1'b0);
    MIDI_RX = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checkOutput("break_busy", 32'(rx_busy), 32'd1);
    idle(20);
    wait_drain("break_frame_err", 40);
    checkOutput("break_idle", 32'(rx_busy), 32'd0);
    checkOutput("break_byteValue", 32'(byteValue), 32'hF8);

    // Reset during data bit 4 of 0xFF, then a clean 0x3C.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    MIDI_RX = 1'b1;
    repeat (BIT / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midreset_byteValue", 32'(byteValue), 32'h00);
    checkOutput("midreset_rx_busy", 32'(rx_busy), 32'd0);
    checkOutput("midreset_pulse", 32'(isByteAvailable), 32'd0);
    model_byte = 8'h00;
    rst = 1'b0;
    idle(BIT * 6);
    checkOutput("aborted_byteValue", 32'(byteValue), 32'h00);
    checkOutput("aborted_rx_busy", 32'(rx_busy), 32'd0);
    applyStimulus(8'h3C, 1'b1);
    idle(20);
    wait_drain("after_reset_frame", 40);
    checkOutput("after_reset_byteValue", 32'(byteValue), 32'h3C);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
